// File: rtl/acq_sequencer.sv
// Capture sequencer for the display sample buffer: pre-trigger fill, edge arming,
// post-trigger fill and frame hold, with auto/normal/single/stop run modes.
module acq_sequencer #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 640,
  parameter int ADDR_W       = 10,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] TRIG,
  input  logic              slope,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              rearm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] start_addr,
  output logic              auto_fired,
  output logic [2:0]        state
);

  localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  TO_LIMIT  = CNT_W'(AUTO_TIMEOUT);

  localparam logic [1:0] M_AUTO   = 2'b00;
  localparam logic [1:0] M_NORMAL = 2'b01;
  localparam logic [1:0] M_STOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_HOLD    = 3'd4,
    S_STOPPED = 3'd5
  } state_t;

  function automatic logic [ADDR_W-1:0] clamp_pre(input logic [ADDR_W-1:0] p);
    return (p > LAST_ADDR) ? LAST_ADDR : p;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // (a - b) mod DEPTH, with both operands already in [0, DEPTH)
  function automatic logic [ADDR_W-1:0] wrap_sub(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (a < b) diff = diff + DEPTH_X;
    return diff[ADDR_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == TO_LIMIT) ? c : c + 1'b1;
  endfunction

  function automatic logic is_edge(input logic [DATA_W-1:0] prv,
                                   input logic [DATA_W-1:0] cur,
                                   input logic [DATA_W-1:0] lvl,
                                   input logic              slp);
    if (!slp) return (prv < lvl) && (cur >= lvl);
    else      return (prv > lvl) && (cur <= lvl);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pre_n_q, pre_n_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0]   post_left_q, post_left_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                have_prev_q, have_prev_d;
  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                frame_ready_q, frame_ready_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic                auto_fired_q, auto_fired_d;

  logic                do_write;
  logic                enter_pre;
  logic                edge_hit;
  logic                forced;
  logic                run_mode;
  logic [ADDR_W-1:0]   post_n;

  assign run_mode = (mode == M_AUTO) || (mode == M_NORMAL);
  assign post_n   = LAST_ADDR - pre_n_q;

  always_comb begin
    state_d       = state_q;
    pre_n_d       = pre_n_q;
    pre_cnt_d     = pre_cnt_q;
    post_left_d   = post_left_q;
    trig_addr_d   = trig_addr_q;
    ptr_d         = ptr_q;
    prev_d        = prev_q;
    have_prev_d   = have_prev_q;
    to_cnt_d      = to_cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_ready_d = frame_ready_q;
    start_addr_d  = start_addr_q;
    auto_fired_d  = 1'b0;
    do_write      = 1'b0;
    enter_pre     = 1'b0;
    edge_hit      = 1'b0;
    forced        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run_mode) enter_pre = 1'b1;
        else          state_d   = S_STOPPED;
      end

      S_PRE: begin
        if (mode == M_STOP) begin
          state_d = S_STOPPED;
        end else if (pre_n_q == '0) begin
          state_d  = S_ARMED;
          to_cnt_d = '0;
        end else if (sample_valid) begin
          do_write    = 1'b1;
          prev_d      = sample;
          have_prev_d = 1'b1;
          if (pre_cnt_q == pre_n_q - 1'b1) begin
            state_d  = S_ARMED;
            to_cnt_d = '0;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end
      end

      S_ARMED: begin
        if (mode == M_STOP) begin
          state_d = S_STOPPED;
        end else if (sample_valid) begin
          do_write    = 1'b1;
          prev_d      = sample;
          have_prev_d = 1'b1;
          edge_hit    = have_prev_q && is_edge(prev_q, sample, TRIG, slope);
          forced      = !edge_hit && (mode == M_AUTO) && (to_cnt_q == TO_LIMIT);
          if (edge_hit || forced) begin
            trig_addr_d  = ptr_q;
            auto_fired_d = forced;
            post_left_d  = post_n;
            state_d      = S_POST;
            // With no post-trigger samples the trigger write itself completes the frame
            if (post_n == '0) begin
              frame_ready_d = 1'b1;
              start_addr_d  = wrap_sub(ptr_q, pre_n_q);
            end
          end else begin
            to_cnt_d = sat_inc(to_cnt_q);
          end
        end
      end

      S_POST: begin
        if (mode == M_STOP) begin
          state_d = S_STOPPED;
        end else if (post_left_q == '0) begin
          state_d = S_HOLD;
        end else if (sample_valid) begin
          do_write    = 1'b1;
          post_left_d = post_left_q - 1'b1;
          if (post_left_q == ADDR_W'(1)) begin
            state_d       = S_HOLD;
            frame_ready_d = 1'b1;
            start_addr_d  = wrap_sub(trig_addr_q, pre_n_q);
          end
        end
      end

      S_HOLD: begin
        if (rearm) begin
          if (run_mode) enter_pre = 1'b1;
          else          state_d   = S_STOPPED;
        end
      end

      S_STOPPED: begin
        if (rearm && (mode != M_STOP)) enter_pre = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    if (enter_pre) begin
      state_d       = S_PRE;
      pre_n_d       = clamp_pre(pretrig);
      pre_cnt_d     = '0;
      have_prev_d   = 1'b0;
      frame_ready_d = 1'b0;
    end

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = sample;
      ptr_d     = wrap_inc(ptr_q);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pre_n_q       <= '0;
      pre_cnt_q     <= '0;
      post_left_q   <= '0;
      trig_addr_q   <= '0;
      ptr_q         <= '0;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      to_cnt_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_ready_q <= 1'b0;
      start_addr_q  <= '0;
      auto_fired_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_n_q       <= pre_n_d;
      pre_cnt_q     <= pre_cnt_d;
      post_left_q   <= post_left_d;
      trig_addr_q   <= trig_addr_d;
      ptr_q         <= ptr_d;
      prev_q        <= prev_d;
      have_prev_q   <= have_prev_d;
      to_cnt_q      <= to_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_ready_q <= frame_ready_d;
      start_addr_q  <= start_addr_d;
      auto_fired_q  <= auto_fired_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_ready = frame_ready_q;
  assign start_addr  = start_addr_q;
  assign auto_fired  = auto_fired_q;
  assign state       = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed scoreboard bench for acq_sequencer with a 16-sample frame and short
// auto timeout; expected buffer writes are queued by the driver and popped by a monitor.
module tb_acq_sequencer;

  localparam int DW = 12;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int TO = 8;

  logic          CLK;
  logic          reset;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic [DW-1:0] TRIG;
  logic          slope;
  logic [1:0]    mode;
  logic [AW-1:0] pretrig;
  logic          rearm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_ready;
  logic [AW-1:0] start_addr;
  logic          auto_fired;
  logic [2:0]    state;

  acq_sequencer #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .AUTO_TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .TRIG(TRIG), .slope(slope), .mode(mode), .pretrig(pretrig), .rearm(rearm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ready(frame_ready), .start_addr(start_addr),
    .auto_fired(auto_fired), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          af;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_pass = 0;
  int  exp_ptr = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every presented write must match the oldest queued expectation
  always @(negedge CLK) begin
    if (!reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                   wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", int'(wr_addr), int'(mon_e.addr));
          chk("wr_data", int'(wr_data), int'(mon_e.data));
          chk("auto_fired_on_write", int'(auto_fired), int'(mon_e.af));
        end
      end else if (auto_fired) begin
        n_checks++;
        $display("FAIL stray_auto_fired: got 1 without a write, expected 0");
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v, input bit wr, input bit af);
    wr_t e;
    sample       = v;
    sample_valid = 1'b1;
    if (wr) begin
      e.addr = AW'(exp_ptr);
      e.data = v;
      e.af   = af;
      exp_q.push_back(e);
      exp_ptr = (exp_ptr == DEPTH - 1) ? 0 : exp_ptr + 1;
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_frame_ready"}, int'(frame_ready), 0);
    chk({tag, "_start_addr"}, int'(start_addr), 0);
    chk({tag, "_auto_fired"}, int'(auto_fired), 0);
  endtask

  logic [DW-1:0] sine_post [11] = '{1500, 1000, 600, 300, 100, 50, 100, 300, 600, 1000, 1500};

  initial begin
    reset = 1'b0; sample_valid = 1'b0; sample = '0; TRIG = 12'd2048;
    slope = 1'b0; mode = 2'b01; pretrig = 4'd4; rearm = 1'b0;
    #2 reset = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();
    chk("idle_to_pre", int'(state), 1);

    // Normal mode, rising ramp
    for (int i = 0; i < 4; i++) send(DW'(i * 256), 1, 0);
    chk("pre_done_armed", int'(state), 2);
    for (int i = 4; i < 8; i++) send(DW'(i * 256), 1, 0);
    chk("ramp_below_trig", int'(state), 2);
    send(12'd2048, 1, 0);
    chk("ramp_trigger_post", int'(state), 3);
    for (int i = 0; i < 10; i++) send(DW'(3000 + i), 1, 0);
    chk("ramp_fr_before_last", int'(frame_ready), 0);
    send(12'd3010, 1, 0);
    chk("ramp_frame_ready", int'(frame_ready), 1);
    chk("ramp_start_addr", int'(start_addr), 4);
    chk("ramp_hold", int'(state), 4);
    send(12'd1234, 0, 0);
    chk("hold_discards", int'(state), 4);
    chk("ramp_all_writes_seen", exp_q.size(), 0);

    // Auto mode, flat input forces a trigger after the timeout
    mode = 2'b00;
    pulse_rearm();
    chk("auto_rearm_pre", int'(state), 1);
    chk("auto_rearm_clears_fr", int'(frame_ready), 0);
    for (int i = 0; i < 4; i++) send(12'd100, 1, 0);
    for (int i = 0; i < TO; i++) send(12'd100, 1, 0);
    chk("auto_waiting", int'(state), 2);
    send(12'd100, 1, 1);
    chk("auto_forced_post", int'(state), 3);
    for (int i = 0; i < 10; i++) send(12'd100, 1, 0);
    chk("auto_fr_before_last", int'(frame_ready), 0);
    send(12'd100, 1, 0);
    chk("auto_frame_ready", int'(frame_ready), 1);
    chk("auto_start_addr", int'(start_addr), 12);
    chk("auto_hold", int'(state), 4);

    // Normal mode, flat input never triggers
    mode = 2'b01;
    pulse_rearm();
    chk("normal_rearm_pre", int'(state), 1);
    for (int i = 0; i < 4; i++) send(12'd100, 1, 0);
    for (int i = 0; i < 1000; i++) send(12'd100, 1, 0);
    chk("normal_still_armed", int'(state), 2);
    chk("normal_no_frame", int'(frame_ready), 0);

    // Stop while armed, then single-shot falling-edge capture
    mode = 2'b11;
    tick();
    chk("stop_from_armed", int'(state), 5);
    chk("stop_keeps_start", int'(start_addr), 12);
    mode = 2'b10;
    slope = 1'b1;
    pulse_rearm();
    chk("single_rearm_pre", int'(state), 1);
    send(12'd1000, 1, 0); send(12'd500, 1, 0); send(12'd1000, 1, 0); send(12'd1500, 1, 0);
    send(12'd2600, 1, 0); send(12'd3500, 1, 0);
    chk("falling_ignores_rise", int'(state), 2);
    send(12'd2048, 1, 0);
    chk("falling_trigger", int'(state), 3);
    for (int i = 0; i < 10; i++) send(sine_post[i], 1, 0);
    chk("single_fr_before_last", int'(frame_ready), 0);
    send(sine_post[10], 1, 0);
    chk("single_frame_ready", int'(frame_ready), 1);
    chk("single_start_addr", int'(start_addr), 10);
    pulse_rearm();
    chk("single_rearm_stopped", int'(state), 5);
    chk("single_fr_kept", int'(frame_ready), 1);
    for (int i = 0; i < 3; i++) send(12'd200, 0, 0);
    chk("stopped_no_writes", exp_q.size(), 0);
    chk("stopped_start_kept", int'(start_addr), 10);

    // pretrig = 0, trigger lands on the last address and writes wrap
    pretrig = 4'd0;
    mode = 2'b01;
    slope = 1'b0;
    pulse_rearm();
    chk("wrap_rearm_pre", int'(state), 1);
    chk("wrap_rearm_clears_fr", int'(frame_ready), 0);
    tick();
    chk("pre_zero_armed", int'(state), 2);
    send(12'd3000, 1, 0);
    chk("no_edge_first_sample", int'(state), 2);
    for (int i = 0; i < 4; i++) send(12'd1000, 1, 0);
    send(12'd2048, 1, 0);
    chk("wrap_trigger", int'(state), 3);
    for (int i = 0; i < 14; i++) send(DW'(500 + i), 1, 0);
    chk("wrap_fr_before_last", int'(frame_ready), 0);
    send(12'd514, 1, 0);
    chk("wrap_frame_ready", int'(frame_ready), 1);
    chk("wrap_start_eq_trig", int'(start_addr), 15);

    // Stop midway through POST, then asynchronous reset
    pretrig = 4'd4;
    pulse_rearm();
    chk("abort_rearm_pre", int'(state), 1);
    send(12'd0, 1, 0); send(12'd256, 1, 0); send(12'd512, 1, 0); send(12'd768, 1, 0);
    send(12'd2048, 1, 0);
    chk("abort_trigger", int'(state), 3);
    send(12'd2100, 1, 0); send(12'd2200, 1, 0); send(12'd2300, 1, 0);
    mode = 2'b11;
    send(12'd2400, 0, 0);
    chk("abort_stopped", int'(state), 5);
    chk("abort_start_kept", int'(start_addr), 15);
    chk("abort_writes_seen", exp_q.size(), 0);
    chk("abort_wr_addr_last", int'(wr_addr), 6);
    #3 reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    exp_ptr = 0;
    mode = 2'b01;
    tick();
    reset = 1'b0;
    chk("released_idle", int'(state), 0);
    tick();
    chk("restart_pre", int'(state), 1);
    send(12'd77, 1, 0);
    tick();
    chk("restart_writes_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
